// File: rtl/led_pkg.sv
// Shared encodings and pattern helpers for the LED sequencer.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_CHASE    = 2'd0,
      MODE_BAR      = 2'd1,
      MODE_PINGPONG = 2'd2,
      MODE_BLINK    = 2'd3
   } mode_e;

   // Two-bit encoding leaves spare codes; the FSM folds them back to PP_UP.
   typedef enum logic [1:0] {
      PP_UP   = 2'b01,
      PP_DOWN = 2'b10
   } pp_state_e;

   localparam logic [7:0] PAT_RESET = 8'h01;

   function automatic logic [7:0] onehot8(input logic [2:0] idx);
      return 8'h01 << idx;
   endfunction

   function automatic logic [7:0] therm8(input logic [2:0] idx);
      return 8'hFF >> (3'd7 - idx);
   endfunction

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM counter; on is high for duty of every 2^PWM_W cycles.
module led_pwm #(
   parameter int PWM_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PWM_W-1:0] duty,
   output logic             on
);

   localparam logic [PWM_W-1:0] CNT_ONE = {{(PWM_W-1){1'b0}}, 1'b1};

   logic [PWM_W-1:0] pwm_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pwm_cnt <= '0;
      else        pwm_cnt <= pwm_cnt + CNT_ONE;
   end

   assign on = (pwm_cnt < duty);

endmodule

// File: rtl/led_seq_drv.sv
// LED pattern sequencer: steps on upstream count changes, dims with PWM.
//   state   | meaning
//   PP_UP   | pingpong position climbs toward 7 on each step
//   PP_DOWN | pingpong position falls toward 0 on each step
module led_seq_drv
   import led_pkg::*;
#(
   parameter int PWM_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       count,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [PWM_W-1:0] duty,
   output logic [7:0]       led,
   output logic             step
);

   logic [2:0] count_q;
   logic [2:0] count_qq;
   logic       armed;
   logic       en_q;
   logic       step_ok;

   mode_e      mode_q, mode_nxt, mode_sel;
   pp_state_e  pp_state, state_nxt;
   logic [2:0] pos, pos_nxt;
   logic [7:0] pattern, pattern_nxt;
   logic       upd;
   logic       entering;
   logic       pwm_on;

   assign mode_sel = mode_e'(mode);

   led_pwm #(.PWM_W(PWM_W)) u_pwm (
      .clk   (clk),
      .reset (reset),
      .duty  (duty),
      .on    (pwm_on)
   );

   // armed suppresses a step on the first edge after reset release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q  <= 3'd0;
         count_qq <= 3'd0;
         armed    <= 1'b0;
         en_q     <= 1'b0;
         step     <= 1'b0;
         step_ok  <= 1'b0;
      end else begin
         armed    <= 1'b1;
         count_q  <= count;
         count_qq <= count_q;
         en_q     <= en;
         step     <= armed && (count != count_q);
         step_ok  <= armed && (count != count_q) && en && en_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_q   <= MODE_CHASE;
         pattern  <= PAT_RESET;
         pos      <= 3'd0;
         pp_state <= PP_UP;
         led      <= 8'h00;
      end else begin
         mode_q   <= mode_nxt;
         pattern  <= pattern_nxt;
         pos      <= pos_nxt;
         pp_state <= state_nxt;
         led      <= (en && pwm_on) ? pattern_nxt : 8'h00;
      end
   end

   always_comb begin
      upd         = step_ok && en;
      entering    = 1'b0;
      mode_nxt    = mode_q;
      pattern_nxt = pattern;
      pos_nxt     = pos;
      state_nxt   = (pp_state == PP_DOWN) ? PP_DOWN : PP_UP;

      if (upd) begin
         mode_nxt = mode_sel;
         entering = (mode_sel != mode_q);
         case (mode_sel)
            MODE_CHASE: pattern_nxt = onehot8(count_q);
            MODE_BAR:   pattern_nxt = therm8(count_q);
            MODE_PINGPONG: begin
               if (entering) begin
                  pos_nxt   = 3'd0;
                  state_nxt = PP_UP;
               end else begin
                  case (pp_state)
                     PP_UP: begin
                        if (pos == 3'd7) begin
                           state_nxt = PP_DOWN;
                           pos_nxt   = 3'd6;
                        end else begin
                           pos_nxt   = pos + 3'd1;
                        end
                     end
                     PP_DOWN: begin
                        if (pos == 3'd0) begin
                           state_nxt = PP_UP;
                           pos_nxt   = 3'd1;
                        end else begin
                           pos_nxt   = pos - 3'd1;
                        end
                     end
                     default: begin
                        state_nxt = PP_UP;
                        pos_nxt   = pos;
                     end
                  endcase
               end
               pattern_nxt = onehot8(pos_nxt);
            end
            MODE_BLINK: begin
               if (entering)
                  pattern_nxt = 8'hFF;
               else if ((count_q == 3'd0) && (count_qq == 3'd7))
                  pattern_nxt = ~pattern;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_seq_drv.sv
// Self-checking bench for led_seq_drv: scoreboarded step/pattern checks plus PWM and reset scenarios.
module tb_led_seq_drv;

   localparam int PWM_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [2:0]       count;
   logic             en;
   logic [1:0]       mode;
   logic [PWM_W-1:0] duty;
   logic [7:0]       led;
   logic             step;

   int checks = 0;
   int errors = 0;

   logic [3:0] tb_cyc;
   logic [7:0] exp_q[$];

   led_seq_drv #(.PWM_W(PWM_W)) dut (
      .clk   (clk),
      .reset (reset),
      .count (count),
      .en    (en),
      .mode  (mode),
      .duty  (duty),
      .led   (led),
      .step  (step)
   );

   always #5 clk = ~clk;

   // Reference PWM phase: edges seen since reset release.
   always @(posedge clk or negedge reset) begin
      if (!reset) tb_cyc <= 4'd0;
      else        tb_cyc <= tb_cyc + 4'd1;
   end

   function automatic logic lit_now();
      logic [3:0] ph;
      ph = tb_cyc - 4'd1;
      return (ph < duty);
   endfunction

   task automatic pulse_count(input logic [2:0] c, input logic [7:0] exp,
                              output logic saw, output logic [7:0] led_s,
                              output logic step_s, output logic lit);
      count = c;
      exp_q.push_back(exp);
      saw = 1'b0;
      for (int i = 0; i < 3 && !saw; i++) begin
         @(negedge clk);
         if (step === 1'b1) saw = 1'b1;
      end
      @(negedge clk);
      led_s  = led;
      step_s = step;
      lit    = lit_now();
   endtask

   task automatic test_reset();
      reset = 1'b0; en = 1'b1; mode = 2'd0; duty = 4'd15; count = 3'd0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (led !== 8'h00 || step !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: led=%h step=%b, required led=00 step=0", led, step);
         end
      end
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (step !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_step: step=%b, required 0", step);
         end
         checks++;
         if (led !== (lit_now() ? 8'h01 : 8'h00)) begin
            errors++;
            $display("FAIL reset_release_led cyc%0d: led=%h, required %h", i, led, lit_now() ? 8'h01 : 8'h00);
         end
      end
   endtask

   task automatic test_chase();
      logic saw, step_s, lit;
      logic [7:0] led_s, e;
      logic [2:0] c;
      mode = 2'd0; duty = 4'd15;
      for (int k = 1; k <= 8; k++) begin
         c = k[2:0];
         e = 8'd1 << c;
         pulse_count(c, e, saw, led_s, step_s, lit);
         e = exp_q.pop_front();
         checks++;
         if (!saw) begin errors++; $display("FAIL chase_step c=%0d: step not seen, required pulse", c); end
         checks++;
         if (step_s !== 1'b0) begin errors++; $display("FAIL chase_step_width c=%0d: step=%b, required 0", c, step_s); end
         checks++;
         if (led_s !== (lit ? e : 8'h00)) begin
            errors++; $display("FAIL chase_led c=%0d: led=%h, required %h", c, led_s, lit ? e : 8'h00);
         end
         if (c == 3'd3) begin
            mode = 2'd1;
            repeat (3) @(negedge clk);
            checks++;
            if (led !== (lit_now() ? 8'h08 : 8'h00)) begin
               errors++; $display("FAIL mode_between_steps: led=%h, required %h", led, lit_now() ? 8'h08 : 8'h00);
            end
            mode = 2'd0;
         end
      end
   endtask

   task automatic test_pingpong();
      logic saw, step_s, lit;
      logic [7:0] led_s, e;
      int pp_seq[16];
      pp_seq = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
      mode = 2'd2; duty = 4'd15;
      for (int k = 0; k < 16; k++) begin
         e = 8'd1 << pp_seq[k];
         pulse_count(3'(k + 1), e, saw, led_s, step_s, lit);
         e = exp_q.pop_front();
         checks++;
         if (!saw) begin errors++; $display("FAIL pingpong_step k=%0d: step not seen, required pulse", k); end
         checks++;
         if (led_s !== (lit ? e : 8'h00)) begin
            errors++; $display("FAIL pingpong_led k=%0d: led=%h, required %h", k, led_s, lit ? e : 8'h00);
         end
      end
   endtask

   task automatic test_blink();
      logic saw, step_s, lit;
      logic [7:0] led_s, e, b;
      logic [2:0] c;
      mode = 2'd3; duty = 4'd15; b = 8'hFF;
      for (int k = 1; k <= 17; k++) begin
         c = k[2:0];
         if (k == 1) b = 8'hFF;
         else if (c == 3'd0) b = ~b;
         pulse_count(c, b, saw, led_s, step_s, lit);
         e = exp_q.pop_front();
         checks++;
         if (!saw) begin errors++; $display("FAIL blink_step k=%0d: step not seen, required pulse", k); end
         checks++;
         if (led_s !== (lit ? e : 8'h00)) begin
            errors++; $display("FAIL blink_led k=%0d: led=%h, required %h", k, led_s, lit ? e : 8'h00);
         end
      end
   endtask

   task automatic test_bar_pwm();
      logic saw, step_s, lit;
      logic [7:0] led_s, e;
      int on_cnt;
      mode = 2'd1; duty = 4'd4;
      pulse_count(3'd3, 8'h0F, saw, led_s, step_s, lit);
      e = exp_q.pop_front();
      checks++;
      if (!saw || led_s !== (lit ? e : 8'h00)) begin
         errors++; $display("FAIL bar_step: saw=%b led=%h, required saw=1 led=%h", saw, led_s, lit ? e : 8'h00);
      end
      on_cnt = 0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (led == 8'h0F) on_cnt++;
         checks++;
         if (led !== (lit_now() ? 8'h0F : 8'h00)) begin
            errors++; $display("FAIL bar_pwm4 cyc%0d: led=%h, required %h", i, led, lit_now() ? 8'h0F : 8'h00);
         end
      end
      checks++;
      if (on_cnt != 8) begin errors++; $display("FAIL bar_duty4_ontime: on=%0d of 32, required 8", on_cnt); end
      duty = 4'd0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (led !== 8'h00) begin errors++; $display("FAIL duty0_dark cyc%0d: led=%h, required 00", i, led); end
      end
      duty = 4'd15;
      on_cnt = 0;
      repeat (32) begin
         @(negedge clk);
         if (led == 8'h0F) on_cnt++;
      end
      checks++;
      if (on_cnt != 30) begin errors++; $display("FAIL duty15_ontime: on=%0d of 32, required 30", on_cnt); end
   endtask

   task automatic test_enable();
      logic saw, step_s, lit;
      logic [7:0] led_s, e;
      mode = 2'd0; duty = 4'd15;
      pulse_count(3'd5, 8'h20, saw, led_s, step_s, lit);
      e = exp_q.pop_front();
      checks++;
      if (!saw || led_s !== (lit ? e : 8'h00)) begin
         errors++; $display("FAIL en_setup: saw=%b led=%h, required saw=1 led=%h", saw, led_s, lit ? e : 8'h00);
      end
      en = 1'b0;
      @(negedge clk);
      checks++;
      if (led !== 8'h00) begin errors++; $display("FAIL en_off_dark: led=%h, required 00", led); end
      for (int k = 0; k < 5; k++) begin
         pulse_count(3'(6 + k), 8'h00, saw, led_s, step_s, lit);
         e = exp_q.pop_front();
         checks++;
         if (!saw) begin errors++; $display("FAIL en_off_step k=%0d: step not seen, required pulse", k); end
         checks++;
         if (led_s !== e) begin errors++; $display("FAIL en_off_led k=%0d: led=%h, required %h", k, led_s, e); end
      end
      en = 1'b1;
      pulse_count(3'd3, 8'h20, saw, led_s, step_s, lit);
      e = exp_q.pop_front();
      checks++;
      if (!saw) begin errors++; $display("FAIL en_rise_step: step not seen, required pulse"); end
      checks++;
      if (led_s !== (lit ? e : 8'h00)) begin
         errors++; $display("FAIL en_rise_frozen: led=%h, required %h", led_s, lit ? e : 8'h00);
      end
      pulse_count(3'd4, 8'h10, saw, led_s, step_s, lit);
      e = exp_q.pop_front();
      checks++;
      if (!saw || led_s !== (lit ? e : 8'h00)) begin
         errors++; $display("FAIL en_resume: saw=%b led=%h, required saw=1 led=%h", saw, led_s, lit ? e : 8'h00);
      end
   endtask

   task automatic test_reset_mid();
      logic saw, step_s, lit;
      logic [7:0] led_s, e;
      logic [7:0] pre[3];
      pre = '{8'h01, 8'h02, 8'h04};
      mode = 2'd2; duty = 4'd15;
      for (int k = 0; k < 3; k++) begin
         pulse_count(3'(5 + k), pre[k], saw, led_s, step_s, lit);
         e = exp_q.pop_front();
         checks++;
         if (!saw || led_s !== (lit ? e : 8'h00)) begin
            errors++; $display("FAIL midrst_pre k=%0d: saw=%b led=%h, required saw=1 led=%h", k, saw, led_s, lit ? e : 8'h00);
         end
      end
      count = 3'd0;
      @(posedge clk);
      #1;
      checks++;
      if (step !== 1'b1) begin errors++; $display("FAIL midrst_step_before: step=%b, required 1", step); end
      reset = 1'b0;
      count = 3'd3;
      #1;
      checks++;
      if (led !== 8'h00 || step !== 1'b0) begin
         errors++; $display("FAIL midrst_async: led=%h step=%b, required led=00 step=0", led, step);
      end
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (led !== 8'h00 || step !== 1'b0) begin
            errors++; $display("FAIL midrst_hold: led=%h step=%b, required led=00 step=0", led, step);
         end
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (step !== 1'b0) begin errors++; $display("FAIL midrst_no_step cyc%0d: step=%b, required 0", i, step); end
         checks++;
         if (led !== (lit_now() ? 8'h01 : 8'h00)) begin
            errors++; $display("FAIL midrst_pattern cyc%0d: led=%h, required %h", i, led, lit_now() ? 8'h01 : 8'h00);
         end
      end
      pulse_count(3'd4, 8'h01, saw, led_s, step_s, lit);
      e = exp_q.pop_front();
      checks++;
      if (!saw || led_s !== (lit ? e : 8'h00)) begin
         errors++; $display("FAIL midrst_reenter: saw=%b led=%h, required saw=1 led=%h", saw, led_s, lit ? e : 8'h00);
      end
      pulse_count(3'd5, 8'h02, saw, led_s, step_s, lit);
      e = exp_q.pop_front();
      checks++;
      if (!saw || led_s !== (lit ? e : 8'h00)) begin
         errors++; $display("FAIL midrst_advance: saw=%b led=%h, required saw=1 led=%h", saw, led_s, lit ? e : 8'h00);
      end
   endtask

   initial begin
      test_reset();
      test_chase();
      test_pingpong();
      test_blink();
      test_bar_pwm();
      test_enable();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation still running at %0t, required completion", $time);
      $fatal(1);
   end

endmodule
